// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master frame engine (command byte + data bytes, MSB first).
// Optional feature macro: SPI_LOOPBACK_EN adds i_loopback, which feeds registered MOSI back into rx_sr.
module spi_master_ctrl #(
    parameter int DATA_BYTE_WIDTH = 1,
    parameter int CLK_DIV         = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         load_en,
    input  logic [DATA_BYTE_WIDTH*8+7:0] master_tx_data,
    output logic [DATA_BYTE_WIDTH*8-1:0] master_rx_data,
    output logic                         rx_valid,
    output logic                         busy,
    output logic                         sCLK,
    output logic                         CS,
    output logic                         MOSI,
    input  logic                         MISO
`ifdef SPI_LOOPBACK_EN
    ,
    input  logic                         i_loopback
`endif
);

    localparam int N  = DATA_BYTE_WIDTH * 8 + 8;
    localparam int RW = DATA_BYTE_WIDTH * 8;
    localparam int DW = $clog2(CLK_DIV);
    localparam int CW = $clog2(N + 1);
    localparam logic [DW-1:0] DIV_TC   = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(N);

    if (CLK_DIV < 2) begin : g_bad_clk_div
        $error("spi_master_ctrl: CLK_DIV must be >= 2");
    end

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [N-2:0]    tx_sr_q, tx_sr_d;
    logic [RW-1:0]   rx_sr_q, rx_sr_d;
    logic [RW-1:0]   rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            busy_q, busy_d;
    logic            sclk_q, sclk_d;
    logic            cs_q, cs_d;
    logic            mosi_q, mosi_d;
    logic            div_tc;
    logic            rx_bit;

    // tx_sr holds only the bits not yet driven; the MSB goes straight to MOSI at acceptance
    assign div_tc = (div_q == DIV_TC);

`ifdef SPI_LOOPBACK_EN
    assign rx_bit = i_loopback ? mosi_q : MISO;
`else
    assign rx_bit = MISO;
`endif

    // next-state and registered-output computation for the frame FSM
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        sclk_d     = sclk_q;
        cs_d       = cs_q;
        mosi_d     = mosi_q;
        case (state_q)
            IDLE: begin
                if (load_en) begin
                    tx_sr_d   = master_tx_data[N-2:0];
                    mosi_d    = master_tx_data[N-1];
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                    div_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                div_d = div_tc ? '0 : div_q + 1'b1;
                if (div_tc) begin
                    sclk_d    = 1'b1;
                    rx_sr_d   = {rx_sr_q[RW-2:0], rx_bit};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                div_d = div_tc ? '0 : div_q + 1'b1;
                if (div_tc && !sclk_q) begin
                    sclk_d    = 1'b1;
                    rx_sr_d   = {rx_sr_q[RW-2:0], rx_bit};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (div_tc) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        mosi_d  = tx_sr_q[N-2];
                        tx_sr_d = {tx_sr_q[N-3:0], 1'b0};
                    end
                end
            end
            HOLD: begin
                div_d = div_tc ? '0 : div_q + 1'b1;
                if (div_tc) begin
                    cs_d       = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    state_d    = GAP;
                end
            end
            GAP: begin
                div_d = div_tc ? '0 : div_q + 1'b1;
                if (div_tc) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
        end
    end

    assign master_rx_data = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign busy           = busy_q;
    assign sCLK           = sclk_q;
    assign CS             = cs_q;
    assign MOSI           = mosi_q;

endmodule
